// File: rtl/rx_symbol_capture_if.sv
// rx_symbol_capture_if: word-wide memory write port driven by the symbol capture block.
// master drives the strobes, address and data; slave is the memory side.
interface rx_symbol_capture_if;
    logic [9:0]  mem_address;
    logic        mem_clken;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;

    modport master (
        output mem_address,
        output mem_clken,
        output mem_chipselect,
        output mem_write,
        output mem_writedata,
        output mem_byteenable
    );

    modport slave (
        input mem_address,
        input mem_clken,
        input mem_chipselect,
        input mem_write,
        input mem_writedata,
        input mem_byteenable
    );
endinterface

// File: rtl/rx_symbol_capture.sv
// rx_symbol_capture: Gray-decodes PAM4 symbols, packs 16 per word, writes words to memory.
// Optional PRBS7 bit-error checker on the decoded stream: define RX_PRBS_CHECK_EN.
module rx_symbol_capture #(
    parameter int NUM_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          symbol_in,
    input  logic                symbol_in_valid,
    rx_symbol_capture_if.master mem,
    output logic                busy,
    output logic                done,
    output logic [10:0]         words_written,
    output logic [31:0]         bit_err_cnt
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    localparam logic [10:0] NW = 11'(NUM_WORDS);
    localparam logic [9:0]  BA = 10'(BASE_ADDR);

    state_t      state, state_nx;
    logic [29:0] shreg;
    logic [3:0]  sym_cnt;
    logic [9:0]  addr;
    logic        wr;
    logic [1:0]  dec;
    logic        go, accept, last_sym, final_wr;

    assign dec      = {symbol_in[1], symbol_in[1] ^ symbol_in[0]};
    assign last_sym = accept && (sym_cnt == 4'd15);
    assign final_wr = wr && (words_written + 11'd1 == NW);

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!abort && start) begin
                    go       = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    accept = symbol_in_valid;
                    if (final_wr) state_nx = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (start) begin
                    go       = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write strobe lags the 16th symbol by one cycle; address advances with it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= IDLE;
            shreg             <= '0;
            sym_cnt           <= '0;
            addr              <= '0;
            wr                <= 1'b0;
            words_written     <= '0;
            mem.mem_address   <= '0;
            mem.mem_writedata <= '0;
        end else begin
            state <= state_nx;
            wr    <= last_sym;
            if (wr) words_written <= words_written + 11'd1;
            if (go) begin
                addr          <= BA;
                sym_cnt       <= '0;
                words_written <= '0;
            end
            if (accept) begin
                shreg   <= {dec, shreg[29:2]};
                sym_cnt <= sym_cnt + 4'd1;
            end
            if (last_sym) begin
                mem.mem_address   <= addr;
                mem.mem_writedata <= {dec, shreg};
                addr              <= addr + 10'd1;
            end
        end
    end

    assign busy               = (state == CAPTURE);
    assign done               = (state == DONE);
    assign mem.mem_write      = wr;
    assign mem.mem_chipselect = wr;
    assign mem.mem_clken      = wr;
    assign mem.mem_byteenable = {4{wr}};

`ifdef RX_PRBS_CHECK_EN
    logic [6:0]  lfsr, lfsr_mid;
    logic [2:0]  seeded;
    logic        p1, p0, e1, e0, in1, in0;
    logic [32:0] err_sum;

    // Seed from the first 7 received bits, then free-run and compare.
    always_comb begin
        p1       = lfsr[6] ^ lfsr[5];
        e1       = (seeded == 3'd7) && (dec[1] != p1);
        in1      = (seeded == 3'd7) ? p1 : dec[1];
        lfsr_mid = {lfsr[5:0], in1};
        p0       = lfsr_mid[6] ^ lfsr_mid[5];
        e0       = (seeded >= 3'd6) && (dec[0] != p0);
        in0      = (seeded >= 3'd6) ? p0 : dec[0];
        err_sum  = {1'b0, bit_err_cnt} + 33'(e1) + 33'(e0);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lfsr        <= '0;
            seeded      <= '0;
            bit_err_cnt <= '0;
        end else if (go) begin
            lfsr        <= '0;
            seeded      <= '0;
            bit_err_cnt <= '0;
        end else if (accept) begin
            lfsr        <= {lfsr_mid[5:0], in0};
            seeded      <= (seeded >= 3'd6) ? 3'd7 : seeded + 3'd2;
            bit_err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
`else
    assign bit_err_cnt = '0;
`endif
endmodule

// File: tb/tb_rx_symbol_capture.sv
// tb_rx_symbol_capture: two capture instances against a word/bit-level reference model.
// Directed scenarios with literal expectations, then randomized traffic and reset.
module tb_rx_symbol_capture;
`ifdef RX_PRBS_CHECK_EN
    localparam int PRBS_ON = 1;
`else
    localparam int PRBS_ON = 0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, vld = 1'b0;
    logic [1:0] sym = 2'b00;

    always #5 clk = ~clk;

    rx_symbol_capture_if ifa ();
    rx_symbol_capture_if ifb ();

    logic        busy_o[2], done_o[2];
    logic [10:0] ww_o[2];
    logic [31:0] bec_o[2];
    logic        wr_o[2], cs_o[2], ce_o[2];
    logic [3:0]  be_o[2];
    logic [9:0]  addr_o[2];
    logic [31:0] data_o[2];

    rx_symbol_capture #(.NUM_WORDS(3), .BASE_ADDR(1022)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
        .symbol_in(sym), .symbol_in_valid(vld), .mem(ifa.master),
        .busy(busy_o[0]), .done(done_o[0]), .words_written(ww_o[0]),
        .bit_err_cnt(bec_o[0]));

    rx_symbol_capture #(.NUM_WORDS(1), .BASE_ADDR(5)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
        .symbol_in(sym), .symbol_in_valid(vld), .mem(ifb.master),
        .busy(busy_o[1]), .done(done_o[1]), .words_written(ww_o[1]),
        .bit_err_cnt(bec_o[1]));

    assign wr_o[0] = ifa.mem_write;      assign wr_o[1] = ifb.mem_write;
    assign cs_o[0] = ifa.mem_chipselect; assign cs_o[1] = ifb.mem_chipselect;
    assign ce_o[0] = ifa.mem_clken;      assign ce_o[1] = ifb.mem_clken;
    assign be_o[0] = ifa.mem_byteenable; assign be_o[1] = ifb.mem_byteenable;
    assign addr_o[0] = ifa.mem_address;  assign addr_o[1] = ifb.mem_address;
    assign data_o[0] = ifa.mem_writedata; assign data_o[1] = ifb.mem_writedata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %h want %h", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: capture progress as symbol counts, word values and a bit history.
    int          NW[2] = '{3, 1};
    int          BA[2] = '{1022, 5};
    int          dec_tab[4] = '{0, 1, 3, 2};
    int          m_st[2], m_k[2], m_addr[2], m_ww[2], m_err[2], m_nb[2];
    bit          m_pend[2];
    logic [31:0] m_word[2], e_data[2];
    logic [9:0]  e_addr[2];
    bit          expb[2][256];

    function automatic void m_reset(int i);
        m_st[i] = 0; m_k[i] = 0; m_addr[i] = 0; m_ww[i] = 0; m_err[i] = 0;
        m_nb[i] = 0; m_pend[i] = 0; m_word[i] = 0; e_data[i] = 0; e_addr[i] = 0;
    endfunction

    function automatic void m_start(int i);
        m_st[i] = 1; m_addr[i] = BA[i]; m_k[i] = 0; m_word[i] = 0;
        m_ww[i] = 0; m_err[i] = 0; m_nb[i] = 0;
    endfunction

    function automatic void m_push(int i, bit b);
        bit e;
        if (m_nb[i] < 7) e = b;
        else begin
            e = expb[i][m_nb[i] - 6] ^ expb[i][m_nb[i] - 7];
            if (e != b) m_err[i]++;
        end
        if (m_nb[i] < 256) expb[i][m_nb[i]] = e;
        if (m_nb[i] < 255) m_nb[i]++;
    endfunction

    function automatic void m_step(int i);
        bit wr_now;
        int d;
        wr_now = m_pend[i];
        m_pend[i] = 0;
        if (wr_now) m_ww[i]++;
        if (m_st[i] == 0) begin
            if (!abort && start) m_start(i);
        end else if (m_st[i] == 1) begin
            if (abort) m_st[i] = 0;
            else begin
                if (vld) begin
                    d = dec_tab[sym];
                    m_word[i] |= 32'(d) << (2 * m_k[i]);
                    m_push(i, d[1]);
                    m_push(i, d[0]);
                    m_k[i]++;
                    if (m_k[i] == 16) begin
                        m_pend[i] = 1; e_addr[i] = 10'(m_addr[i]); e_data[i] = m_word[i];
                        m_addr[i] = (m_addr[i] + 1) % 1024; m_k[i] = 0; m_word[i] = 0;
                    end
                end
                if (wr_now && m_ww[i] == NW[i]) m_st[i] = 2;
            end
        end else begin
            if (abort) m_st[i] = 0;
            else if (start) m_start(i);
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) m_reset(i);
            else m_step(i);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("strobes", i, {25'd0, wr_o[i], cs_o[i], ce_o[i], be_o[i]},
                    m_pend[i] ? 32'h7F : 32'h0);
                chk("address", i, {22'd0, addr_o[i]}, {22'd0, e_addr[i]});
                chk("writedata", i, data_o[i], e_data[i]);
                chk("busy", i, {31'd0, busy_o[i]}, {31'd0, m_st[i] == 1});
                chk("done", i, {31'd0, done_o[i]}, {31'd0, m_st[i] == 2});
                chk("words_written", i, {21'd0, ww_o[i]}, 32'(m_ww[i]));
                chk("bit_err_cnt", i, bec_o[i], PRBS_ON != 0 ? 32'(m_err[i]) : 32'h0);
            end
        end
    end

    int          nwr[2] = '{0, 0};
    logic [9:0]  waddr[2][64];
    logic [31:0] wdata[2][64];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_o[i]) begin
                    if (nwr[i] < 64) begin
                        waddr[i][nwr[i]] = addr_o[i];
                        wdata[i][nwr[i]] = data_o[i];
                    end
                    nwr[i]++;
                end
            end
        end
    end

    task automatic cyc(input bit s, input bit a, input bit v, input logic [1:0] y);
        start = s; abort = a; vld = v; sym = y;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; vld = 1'b0;
    endtask

    task automatic zero_chk(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_strobes"}, i, {25'd0, wr_o[i], cs_o[i], ce_o[i], be_o[i]}, 0);
            chk({nm, "_addr"}, i, {22'd0, addr_o[i]}, 0);
            chk({nm, "_data"}, i, data_o[i], 0);
            chk({nm, "_status"}, i, {30'd0, busy_o[i], done_o[i]}, 0);
            chk({nm, "_ww"}, i, {21'd0, ww_o[i]}, 0);
            chk({nm, "_bec"}, i, bec_o[i], 0);
        end
    endtask

    int         b0, b1;
    logic [1:0] pat[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    bit         pb[96];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        b0 = nwr[0]; b1 = nwr[1];
        cyc(1, 0, 0, 2'b00);
        for (int j = 0; j < 16; j++) cyc(0, 0, 1, 2'b10);
        chk("single_wr_latency", 1, {31'd0, wr_o[1]}, 1);
        cyc(0, 0, 0, 2'b00);
        chk("single_nwr", 1, 32'(nwr[1] - b1), 1);
        chk("single_addr", 1, {22'd0, waddr[1][b1]}, 5);
        chk("single_data", 1, wdata[1][b1], 32'hFFFFFFFF);
        chk("single_done_ww", 1, {20'd0, done_o[1], ww_o[1]}, {20'd1, 11'd1});
        chk("single_a_addr", 0, {22'd0, waddr[0][b0]}, 1022);

        cyc(0, 1, 0, 2'b00);
        for (int j = 0; j < 5; j++) cyc(0, 0, 1, 2'($urandom));
        b0 = nwr[0]; b1 = nwr[1];
        cyc(1, 0, 0, 2'b00);
        for (int j = 0; j < 48; j++) begin
            cyc(0, 0, 1, pat[j % 4]);
            cyc(j == 5, 0, 0, 2'b00);
        end
        chk("gap_nwr", 0, 32'(nwr[0] - b0), 3);
        chk("gap_addr0", 0, {22'd0, waddr[0][b0]}, 1022);
        chk("gap_addr1", 0, {22'd0, waddr[0][b0 + 1]}, 1023);
        chk("gap_addr2", 0, {22'd0, waddr[0][b0 + 2]}, 0);
        for (int k = 0; k < 3; k++) chk("gap_data", 0, wdata[0][b0 + k], 32'hE4E4E4E4);
        chk("gap_done_ww", 0, {20'd0, done_o[0], ww_o[0]}, {20'd1, 11'd3});
        chk("gap_b_data", 1, wdata[1][b1], 32'hE4E4E4E4);

        b0 = nwr[0];
        for (int j = 0; j < 20; j++) cyc(0, 0, 1, 2'($urandom));
        chk("done_ign_nwr", 0, 32'(nwr[0] - b0), 0);
        chk("done_ign_ww", 0, {21'd0, ww_o[0]}, 3);
        chk("done_ign_addr", 0, {22'd0, addr_o[0]}, 0);
        chk("done_ign_data", 0, data_o[0], 32'hE4E4E4E4);

        b0 = nwr[0];
        cyc(1, 0, 0, 2'b00);
        for (int j = 0; j < 31; j++) cyc(0, 0, 1, 2'($urandom));
        cyc(0, 1, 1, 2'($urandom));
        chk("abort_state", 0, {30'd0, busy_o[0], done_o[0]}, 0);
        chk("abort_ww", 0, {21'd0, ww_o[0]}, 1);
        repeat (3) cyc(0, 0, 0, 2'b00);
        chk("abort_nwr", 0, 32'(nwr[0] - b0), 1);

        for (int n = 0; n < 96; n++) pb[n] = (n < 7) ? 1'b1 : pb[n - 6] ^ pb[n - 7];
        pb[20] = ~pb[20]; pb[51] = ~pb[51]; pb[90] = ~pb[90];
        cyc(1, 0, 0, 2'b00);
        for (int j = 0; j < 48; j++)
            cyc(0, 0, 1, {pb[2 * j], pb[2 * j] ^ pb[2 * j + 1]});
        repeat (2) cyc(0, 0, 0, 2'b00);
        chk("prbs_errs", 0, bec_o[0], PRBS_ON != 0 ? 32'd3 : 32'd0);
        chk("prbs_errs", 1, bec_o[1], PRBS_ON != 0 ? 32'd1 : 32'd0);

        for (int j = 0; j < 3000; j++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 3) != 0, 2'($urandom));

        cyc(0, 1, 0, 2'b00);
        cyc(1, 0, 0, 2'b00);
        for (int j = 0; j < 20; j++) cyc(0, 0, 1, 2'($urandom));
        vld = 1'b1; sym = 2'b11;
        #2 rst_n = 1'b0;
        #1 zero_chk("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b0 = nwr[0]; b1 = nwr[1];
        for (int j = 0; j < 20; j++) cyc(0, 0, 1, 2'($urandom));
        chk("post_rst_nwr", 0, 32'(nwr[0] - b0), 0);
        chk("post_rst_nwr", 1, 32'(nwr[1] - b1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
